// File: rtl/mips_pkg.sv
// Shared MIPS control constants, multicycle state type and control bundle.
package mips_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OPC   = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11
    } mc_state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } mc_ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Moore output decoder: maps controller state (and op, for ORI
// zero-extension) to the datapath control bundle.
module mc_outdec
    import mips_pkg::*;
(
    input  mc_state_t  state,
    input  logic [5:0] op,
    output mc_ctrl_t   ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_DECODE: begin
                ctrl.alusrcb = 2'b11;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.branch  = 1'b1;
                ctrl.pcsrc   = 2'b01;
            end
            S_IMMEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.aluop   = ALUOP_OPC;
                ctrl.zeroext = (op == OP_ORI);
            end
            S_IMMWB: begin
                ctrl.regwrite = 1'b1;
            end
            S_JEX: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = 2'b10;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller: state register, next-state logic,
// reset gating of the write enables and PC enable generation.
module mc_maindec
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop
);

    mc_state_t state_q;
    mc_state_t state_d;
    mc_ctrl_t  ctrl;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE:        state_d = S_RTYPEEX;
                    OP_BEQ:          state_d = S_BEQEX;
                    OP_ADDI, OP_ORI: state_d = S_IMMEX;
                    OP_J:            state_d = S_JEX;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_IMMEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    mc_outdec u_outdec (
        .state (state_q),
        .op    (op),
        .ctrl  (ctrl)
    );

    // Write enables are held off for as long as reset is low.
    assign pcen     = reset_n & (ctrl.pcwrite | (ctrl.branch & zero));
    assign memwrite = reset_n & ctrl.memwrite;
    assign irwrite  = reset_n & ctrl.irwrite;
    assign regwrite = reset_n & ctrl.regwrite;
    assign iord     = ctrl.iord;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign zeroext  = ctrl.zeroext;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: instruction-path model plus directed sequences.
module tb_mc_maindec;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, iord, regdst;
    logic       memtoreg, alusrca, zeroext;
    logic [1:0] alusrcb, pcsrc, aluop;

    int checks = 0;
    int errors = 0;
    int step   = 0;
    bit cmp_en = 0;

    mc_maindec dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op       (op),
        .zero     (zero),
        .pcen     (pcen),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .regwrite (regwrite),
        .iord     (iord),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .zeroext  (zeroext),
        .pcsrc    (pcsrc),
        .aluop    (aluop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phases: 0 F,1 D,2 MA,3 MR,4 MW,5 MWR,6 RE,7 RW,8 BE,9 IE,10 IW,11 JE
    function automatic int phase_of(input logic [5:0] o, input int s);
        int p[5];
        int n;
        p = '{0, 1, 0, 0, 0};
        n = 2;
        case (o)
            6'b100011: begin p = '{0, 1, 2, 3, 4}; n = 5; end
            6'b101011: begin p = '{0, 1, 2, 5, 0}; n = 4; end
            6'b000000: begin p = '{0, 1, 6, 7, 0}; n = 4; end
            6'b000100: begin p = '{0, 1, 8, 0, 0}; n = 3; end
            6'b001000,
            6'b001101: begin p = '{0, 1, 9, 10, 0}; n = 4; end
            6'b000010: begin p = '{0, 1, 11, 0, 0}; n = 3; end
            default:   begin p = '{0, 1, 0, 0, 0}; n = 2; end
        endcase
        return (s < n) ? p[s] : -1;
    endfunction

    // {pcen,memwrite,irwrite,regwrite,iord,regdst,memtoreg,alusrca,
    //  alusrcb,zeroext,pcsrc,aluop}
    function automatic logic [14:0] expv(input int ph, input logic [5:0] o,
                                         input logic z, input logic rn);
        logic pw, br, mw, iw, rw, io, rd, mr, sa, ze;
        logic [1:0] sb, ps, ao;
        {pw, br, mw, iw, rw, io, rd, mr, sa, ze} = '0;
        sb = 2'b00; ps = 2'b00; ao = 2'b00;
        case (ph)
            0:  begin iw = 1; pw = 1; sb = 2'b01; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  io = 1;
            4:  begin rw = 1; mr = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ao = 2'b01; br = 1; ps = 2'b01; end
            9:  begin sa = 1; sb = 2'b10; ao = 2'b11; ze = (o == 6'b001101); end
            10: rw = 1;
            11: begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {(pw | (br & z)) & rn, mw & rn, iw & rn, rw & rn, io, rd, mr,
                sa, sb, ze, ps, ao};
    endfunction

    function automatic int plen(input logic [5:0] o);
        int n;
        n = 0;
        while (n < 6 && phase_of(o, n) != -1) n++;
        return n;
    endfunction

    logic [14:0] act;
    assign act = {pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg,
                  alusrca, alusrcb, zeroext, pcsrc, aluop};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step = 0;
        end else begin
            step = step + 1;
            if (step >= plen(op)) step = 0;
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (cmp_en) begin
            logic [14:0] e;
            e = expv(phase_of(op, step), op, zero, reset_n);
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL ctrl op=%b step=%0d got=%b want=%b",
                         op, step, act, e);
            end
        end
    end

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, a, e);
        end
    endtask

    task automatic run(input logic [5:0] o, input logic z, input int ncyc,
                       input string nm);
        int n;
        op = o;
        zero = z;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (step != 0 && n < 20);
        chk(nm, n, ncyc);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        op = 6'b000000;
        zero = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_irwrite", int'(irwrite), 0);
        chk("rst_pcen", int'(pcen), 0);
        chk("rst_memwrite", int'(memwrite), 0);
        chk("rst_regwrite", int'(regwrite), 0);
        chk("rst_alusrcb", int'(alusrcb), 1);
        reset_n = 1'b1;
        #1;
        chk("rel_irwrite", int'(irwrite), 1);
        chk("rel_pcen", int'(pcen), 1);

        run(6'b100011, 1'b0, 5, "lw_cycles");
        chk("lw_back_fetch", int'(irwrite), 1);
        run(6'b101011, 1'b0, 4, "sw_cycles");
        run(6'b000000, 1'b0, 4, "rtype_cycles");
        run(6'b000100, 1'b1, 3, "beq_taken_cycles");
        run(6'b000100, 1'b0, 3, "beq_nt_cycles");
        run(6'b001101, 1'b0, 4, "ori_cycles");
        run(6'b001000, 1'b0, 4, "addi_cycles");
        run(6'b000010, 1'b0, 3, "j_cycles");
        run(6'b111111, 1'b0, 2, "illegal_cycles");

        // R-type aborted by reset while in RTYPEEX
        op = 6'b000000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_abort_aluop", int'(aluop), 2);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_alusrcb", int'(alusrcb), 1);
        chk("abort_aluop", int'(aluop), 0);
        chk("abort_alusrca", int'(alusrca), 0);
        chk("abort_regwrite", int'(regwrite), 0);
        repeat (2) begin
            @(posedge clk);
            #2;
            chk("abort_hold_regwrite", int'(regwrite), 0);
            chk("abort_hold_regdst", int'(regdst), 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("restart_irwrite", int'(irwrite), 1);
        run(6'b001000, 1'b0, 4, "post_abort_addi");

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
